// File: rtl/i2c_cfg_sequencer.sv
// Walks a configuration table and programs each entry into an I2C master over a local bus,
// polling the master's status with NACK retry and a poll timeout.
module i2c_cfg_sequencer #(
    parameter int unsigned LB_DATA_W   = 32,
    parameter int unsigned LB_ADDR_W   = 8,
    parameter int unsigned TBL_ADDR_W  = 6,
    parameter logic [7:0]  CLK_DIV_VAL = 8'd250,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned LAUNCH_WAIT = 4,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned REG_ADDR    = 'h00,
    parameter int unsigned CLKDIV      = 'h01,
    parameter int unsigned CONFIG      = 'h02,
    parameter int unsigned STATUS      = 'h03,
    parameter int unsigned CACHE_BASE  = 'h10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [TBL_ADDR_W-1:0] tbl_addr,
    input  logic [31:0]           tbl_data,
    output logic                  lb_wr_en,
    output logic                  lb_rd_en,
    output logic [LB_ADDR_W-1:0]  lb_addr,
    output logic [LB_DATA_W-1:0]  lb_wr_data,
    input  logic                  lb_wr_valid,
    input  logic                  lb_rd_valid,
    input  logic [LB_DATA_W-1:0]  lb_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [TBL_ADDR_W-1:0] err_idx,
    output logic [1:0]            err_code
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        StIdle, StClkdiv, StFetch, StWrAddr, StWrD0, StWrD1, StWrCfg,
        StLaunch, StPollRd, StPollChk, StNext, StDone, StErr
    } state_e;

    state_e               state_q, state_d, wr_next;
    logic                 pend_q, pend_d;
    logic [22:0]          entry_q, entry_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [1:0]           status_q, status_d;
    logic [TBL_ADDR_W-1:0] tbl_addr_d, err_idx_d;
    logic                 wr_en_d, rd_en_d, busy_d, done_d, err_d;
    logic [LB_ADDR_W-1:0] addr_d, wr_addr;
    logic [LB_DATA_W-1:0] wdata_d, wr_data;
    logic [1:0]           err_code_d;
    logic                 poll_phase;

    logic unused_bits;
    assign unused_bits = ^{tbl_data[7:0], lb_rd_data[LB_DATA_W-1:2]};

    // Address, data and successor for whichever write state is current
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        wr_next = StIdle;
        case (state_q)
            StClkdiv: begin
                wr_addr = LB_ADDR_W'(CLKDIV);
                wr_data = LB_DATA_W'(CLK_DIV_VAL);
                wr_next = StFetch;
            end
            StWrAddr: begin
                wr_addr = LB_ADDR_W'(REG_ADDR);
                wr_data = LB_DATA_W'({entry_q[22:16], 1'b0});
                wr_next = StWrD0;
            end
            StWrD0: begin
                wr_addr = LB_ADDR_W'(CACHE_BASE);
                wr_data = LB_DATA_W'(entry_q[15:8]);
                wr_next = StWrD1;
            end
            StWrD1: begin
                wr_addr = LB_ADDR_W'(CACHE_BASE + 1);
                wr_data = LB_DATA_W'(entry_q[7:0]);
                wr_next = StWrCfg;
            end
            StWrCfg: begin
                wr_addr = LB_ADDR_W'(CONFIG);
                wr_data = LB_DATA_W'(32'h0000_0207);
                wr_next = StLaunch;
            end
            default: ;
        endcase
    end

    assign poll_phase = (state_q == StLaunch) || (state_q == StPollRd) || (state_q == StPollChk);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        entry_d    = entry_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        status_d   = status_q;
        tbl_addr_d = tbl_addr;
        err_idx_d  = err_idx;
        err_code_d = err_code;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = lb_addr;
        wdata_d    = lb_wr_data;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StClkdiv;
                    tbl_addr_d = '0;
                    retry_d    = '0;
                    err_code_d = 2'b00;
                    pend_d     = 1'b0;
                end
            end
            StClkdiv, StWrAddr, StWrD0, StWrD1, StWrCfg: begin
                if (!pend_q) begin
                    wr_en_d = 1'b1;
                    pend_d  = 1'b1;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                end else if (lb_wr_valid) begin
                    pend_d  = 1'b0;
                    state_d = wr_next;
                    timer_d = '0;
                end
            end
            StFetch: begin
                // First cycle lets the table read settle; second cycle consumes it
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d  = 1'b0;
                    entry_d = tbl_data[30:8];
                    state_d = tbl_data[31] ? StDone : StWrAddr;
                end
            end
            StLaunch: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TIMEOUT_W'(LAUNCH_WAIT - 1)) state_d = StPollRd;
            end
            StPollRd: begin
                timer_d = timer_q + 1'b1;
                if (!pend_q) begin
                    rd_en_d = 1'b1;
                    pend_d  = 1'b1;
                    addr_d  = LB_ADDR_W'(STATUS);
                end else if (lb_rd_valid) begin
                    pend_d   = 1'b0;
                    status_d = lb_rd_data[1:0];
                    state_d  = StPollChk;
                end
            end
            StPollChk: begin
                timer_d = timer_q + 1'b1;
                if (status_q[0]) begin
                    state_d = StPollRd;
                end else if (status_q[1]) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StWrCfg;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'b01;
                    end
                end else begin
                    state_d = StNext;
                end
            end
            StNext: begin
                retry_d = '0;
                if (&tbl_addr) begin
                    state_d = StDone;
                end else begin
                    tbl_addr_d = tbl_addr + 1'b1;
                    state_d    = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout wins over everything, including a read still in flight
        if (poll_phase && (&timer_q)) begin
            state_d    = StErr;
            err_code_d = 2'b10;
            pend_d     = 1'b0;
            rd_en_d    = 1'b0;
            addr_d     = lb_addr;
        end

        if (state_d == StErr && state_q != StErr) err_idx_d = tbl_addr;

        busy_d = !(state_d inside {StIdle, StDone, StErr});
        done_d = (state_d == StDone);
        err_d  = (state_d == StErr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            entry_q    <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            status_q   <= '0;
            tbl_addr   <= '0;
            lb_wr_en   <= 1'b0;
            lb_rd_en   <= 1'b0;
            lb_addr    <= '0;
            lb_wr_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_idx    <= '0;
            err_code   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            entry_q    <= entry_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            tbl_addr   <= tbl_addr_d;
            lb_wr_en   <= wr_en_d;
            lb_rd_en   <= rd_en_d;
            lb_addr    <= addr_d;
            lb_wr_data <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            err_idx    <= err_idx_d;
            err_code   <= err_code_d;
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: scripted local-bus slave, table RAM and
// immediate-assertion checks of LB traffic and status outputs.
module tb_i2c_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  tbl_addr;
    logic [31:0] tbl_data = '0;
    logic        lb_wr_en, lb_rd_en;
    logic [7:0]  lb_addr;
    logic [31:0] lb_wr_data;
    logic        lb_wr_valid = 1'b0;
    logic        lb_rd_valid = 1'b0;
    logic [31:0] lb_rd_data  = '0;
    logic        busy, done, err;
    logic [5:0]  err_idx;
    logic [1:0]  err_code;

    logic [31:0] tbl [64];
    logic [7:0]  log_addr [$];
    logic [31:0] log_data [$];
    int n_cmp = 0;
    int n_mis = 0;
    int cfg_writes = 0;
    int n_reads = 0;
    int proto_err = 0;
    logic outst = 1'b0;

    // Per-test slave script, written only by the stimulus block
    int busy_polls = 0;
    int nack_polls = 0;
    int nack_from_cfg = 1000000;
    int base_reads = 0;
    int base_cfg = 0;

    always #5 clk = ~clk;

    i2c_cfg_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .lb_wr_en    (lb_wr_en),
        .lb_rd_en    (lb_rd_en),
        .lb_addr     (lb_addr),
        .lb_wr_data  (lb_wr_data),
        .lb_wr_valid (lb_wr_valid),
        .lb_rd_valid (lb_rd_valid),
        .lb_rd_data  (lb_rd_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_idx     (err_idx),
        .err_code    (err_code)
    );

    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // Slave acks every access one cycle later and scores the one-outstanding rule
    always @(posedge clk) begin
        int k;
        if (!rst_n) begin
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            outst = 1'b0;
        end else begin
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            if ((lb_wr_en && lb_rd_en) || ((lb_wr_en || lb_rd_en) && outst)) proto_err++;
            outst = lb_wr_en || lb_rd_en;
            if (lb_wr_en) begin
                log_addr.push_back(lb_addr);
                log_data.push_back(lb_wr_data);
                if (lb_addr == 8'h02) cfg_writes++;
            end
            if (lb_rd_en) begin
                k = n_reads - base_reads;
                n_reads++;
                if (k < busy_polls) lb_rd_data <= 32'h1;
                else if (k < busy_polls + nack_polls) lb_rd_data <= 32'h2;
                else if (cfg_writes - base_cfg >= nack_from_cfg) lb_rd_data <= 32'h2;
                else lb_rd_data <= 32'h0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag, output int cycles);
        cycles = 0;
        while (!(done || err) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_finished"}, 64'(done || err), 64'd1);
    endtask

    task automatic arm(input int bp, input int np, input int nfc);
        busy_polls    = bp;
        nack_polls    = np;
        nack_from_cfg = nfc;
        base_reads    = n_reads;
        base_cfg      = cfg_writes;
    endtask

    initial begin
        int cyc;
        int nb;
        int found;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 64; i++) tbl[i] = 32'h8000_0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy_done_err", {61'd0, busy, done, err}, 64'd0);
        check("rst_strobes", {62'd0, lb_wr_en, lb_rd_en}, 64'd0);
        check("rst_addr_data", {24'd0, lb_addr, lb_wr_data}, 64'd0);
        check("rst_idx_code", {50'd0, tbl_addr, err_idx, err_code}, 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_lb", 64'(log_addr.size() + n_reads), 64'd0);

        // Single entry, two busy polls, then end marker
        tbl[0] = 32'h1A0F_8000;
        tbl[1] = 32'h8000_0000;
        arm(2, 0, 1000000);
        pulse_start();
        wait_end(2000, "t1", cyc);
        check("t1_done_err", {62'd0, done, err}, 64'd2);
        check("t1_nwr", 64'(log_addr.size()), 64'd5);
        check("t1_w0", {log_addr[0], log_data[0]}, {8'h01, 32'hFA});
        check("t1_w1", {log_addr[1], log_data[1]}, {8'h00, 32'h34});
        check("t1_w2", {log_addr[2], log_data[2]}, {8'h10, 32'h0F});
        check("t1_w3", {log_addr[3], log_data[3]}, {8'h11, 32'h80});
        check("t1_w4", {log_addr[4], log_data[4]}, {8'h02, 32'h207});
        check("t1_reads", 64'(n_reads - base_reads), 64'd3);
        check("t1_tbl_addr", 64'(tbl_addr), 64'd1);

        // Two NACKs then success
        nb = log_addr.size();
        arm(0, 2, 1000000);
        pulse_start();
        check("t2_done_cleared", {62'd0, busy, done}, 64'd2);
        wait_end(2000, "t2", cyc);
        check("t2_done_err", {62'd0, done, err}, 64'd2);
        check("t2_cfg", 64'(cfg_writes - base_cfg), 64'd3);
        check("t2_nwr", 64'(log_addr.size() - nb), 64'd7);

        // Entry 1 NACKs forever
        tbl[1] = 32'h2055_AA00;
        tbl[2] = 32'h8000_0000;
        arm(0, 0, 2);
        pulse_start();
        wait_end(3000, "t3", cyc);
        check("t3_err_done_busy", {61'd0, err, done, busy}, 64'd4);
        check("t3_code", 64'(err_code), 64'd1);
        check("t3_idx", 64'(err_idx), 64'd1);
        check("t3_cfg", 64'(cfg_writes - base_cfg), 64'd5);

        // STATUS stuck busy -> timeout on entry 0
        arm(1000000, 0, 1000000);
        pulse_start();
        wait_end(70000, "t4", cyc);
        check("t4_err", 64'(err), 64'd1);
        check("t4_code", 64'(err_code), 64'd2);
        check("t4_idx", 64'(err_idx), 64'd0);
        check("t4_latency", 64'(cyc >= 65535 && cyc < 65600), 64'd1);
        repeat (5) @(negedge clk);
        check("t4_err_sticky", {62'd0, err, busy}, 64'd2);

        // Full table, no marker, extra start while busy
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'(i);
            tbl[i] = {1'b0, 7'(i + 1), b, ~b, 8'h00};
        end
        nb = log_addr.size();
        arm(0, 0, 1000000);
        pulse_start();
        found = 0;
        for (int c = 0; c < 500 && found == 0; c++) begin
            @(negedge clk);
            if (tbl_addr == 6'd3) found = 1;
        end
        check("t5_reach_idx3", 64'(found), 64'd1);
        pulse_start();
        check("t5_ignored_start", {63'd0, busy}, 64'd1);
        wait_end(5000, "t5", cyc);
        check("t5_done_err_code", {60'd0, done, err, err_code}, 64'h8);
        check("t5_tbl_addr", 64'(tbl_addr), 64'd63);
        check("t5_nwr", 64'(log_addr.size() - nb), 64'd257);
        check("t5_last_reg", {log_addr[nb + 253], log_data[nb + 253]}, {8'h00, 32'h80});
        check("t5_last_d0", {log_addr[nb + 254], log_data[nb + 254]}, {8'h10, 32'h3F});
        check("t5_last_d1", {log_addr[nb + 255], log_data[nb + 255]}, {8'h11, 32'hC0});
        check("t5_last_cfg", {log_addr[nb + 256], log_data[nb + 256]}, {8'h02, 32'h207});

        // Reset in the middle of the data-byte write
        tbl[0] = 32'h1A0F_8000;
        tbl[1] = 32'h8000_0000;
        arm(0, 0, 1000000);
        pulse_start();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (lb_wr_en && lb_addr == 8'h11) found = 1;
        end
        check("t6_saw_wr_d1", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", {61'd0, busy, done, err}, 64'd0);
        check("t6_rst_strobe", {62'd0, lb_wr_en, lb_rd_en}, 64'd0);
        check("t6_rst_bus", {24'd0, lb_addr, lb_wr_data}, 64'd0);
        check("t6_rst_tbl_addr", 64'(tbl_addr), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nb = log_addr.size();
        repeat (10) @(negedge clk);
        check("t6_quiet_after_rst", 64'(log_addr.size() - nb), 64'd0);
        pulse_start();
        wait_end(2000, "t6", cyc);
        check("t6_done", {62'd0, done, err}, 64'd2);
        check("t6_restart_w0", {log_addr[nb], log_data[nb]}, {8'h01, 32'hFA});
        check("t6_restart_w1", {log_addr[nb + 1], log_data[nb + 1]}, {8'h00, 32'h34});

        check("lb_protocol", 64'(proto_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
